// File: rtl/sap_bus_pkg.sv
// sap_bus_pkg: shared W-bus widths and driver-enable helpers
package sap_bus_pkg;
    localparam int BUS_W  = 8;
    localparam int NDRV   = 4;
    localparam int DROP_W = 4;
    function automatic logic [4:0] popcount_drv(input logic [15:0] g);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(g[i]);
        return c;
    endfunction
endpackage

// File: rtl/sap_fwft_fifo.sv
// sap_fwft_fifo: first-word-fall-through buffer with a registered head output
module sap_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = DEPTH[AW:0];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0] occ, occ_left, occ_next;
    logic do_push, do_pop;
    assign empty = occ == '0;
    assign full  = occ == OCC_FULL;
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        rd_next  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        occ_left = do_pop ? occ - (AW+1)'(1) : occ;
        occ_next = do_push ? occ_left + (AW+1)'(1) : occ_left;
    end
    always_ff @(posedge CLK)
        if (do_push && !CLR) mem[wr_ptr] <= din;
    // dout tracks the next head so it holds its last value once the buffer drains
    always_ff @(posedge CLK) begin
        if (CLR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            occ    <= occ_next;
            if (occ_next != '0) dout <= (occ_left == '0) ? din : mem[rd_next];
        end
    end
endmodule

// File: rtl/sap_bus_receiver.sv
// sap_bus_receiver: captures the W-bus when exactly one driver is enabled, flags float/contention/overflow
module sap_bus_receiver #(
    parameter int WIDTH = sap_bus_pkg::BUS_W,
    parameter int NDRV  = sap_bus_pkg::NDRV,
    parameter int DEPTH = 2
) (
    input  logic                           CLK,
    input  logic                           CLR,
    input  logic [WIDTH-1:0]               BUS,
    input  logic [NDRV-1:0]                G,
    input  logic                           LD,
    output logic [WIDTH-1:0]               Q,
    output logic                           QV,
    input  logic                           QR,
    output logic                           FULL,
    output logic                           ERR_FLT,
    output logic                           ERR_CON,
    output logic                           ERR_OVF,
    input  logic                           ERR_CLR,
    output logic [sap_bus_pkg::DROP_W-1:0] DROPS
);
    import sap_bus_pkg::*;
    logic [4:0] n;
    logic empty, pop, push, flt, con, ovf, rej;
    always_comb begin
        n    = popcount_drv(16'(G));
        pop  = QV & QR;
        flt  = LD & (n == 5'd0);
        con  = LD & (n >= 5'd2);
        ovf  = LD & (n == 5'd1) & FULL & ~pop;
        push = LD & (n == 5'd1) & (~FULL | pop);
        rej  = flt | con | ovf;
    end
    assign QV = ~empty;
    sap_fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .CLK  (CLK),
        .CLR  (CLR),
        .push (push),
        .pop  (pop),
        .din  (BUS),
        .dout (Q),
        .empty(empty),
        .full (FULL)
    );
    // a rejection in the same cycle as ERR_CLR survives the clear
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ERR_FLT <= 1'b0;
            ERR_CON <= 1'b0;
            ERR_OVF <= 1'b0;
            DROPS   <= '0;
        end else begin
            ERR_FLT <= (ERR_FLT & ~ERR_CLR) | flt;
            ERR_CON <= (ERR_CON & ~ERR_CLR) | con;
            ERR_OVF <= (ERR_OVF & ~ERR_CLR) | ovf;
            DROPS   <= ERR_CLR ? DROP_W'(rej) : (rej && DROPS != '1) ? DROPS + DROP_W'(1) : DROPS;
        end
    end
endmodule

// File: tb/tb_sap_bus_receiver.sv
// tb_sap_bus_receiver: directed scenarios plus randomized traffic checked against a queue model
module tb_sap_bus_receiver;
    localparam int DEPTH = 2;
    logic CLK = 1'b0;
    logic CLR, LD, QR, ERR_CLR, QV, FULL, ERR_FLT, ERR_CON, ERR_OVF;
    logic [7:0] BUS, Q;
    logic [3:0] G, DROPS;
    int total = 0;
    int bad = 0;
    logic [7:0] m_fifo[$];
    logic [7:0] m_q;
    bit m_flt, m_con, m_ovf;
    int m_drops;

    always #5 CLK = ~CLK;

    sap_bus_receiver dut (
        .CLK(CLK), .CLR(CLR), .BUS(BUS), .G(G), .LD(LD), .Q(Q), .QV(QV), .QR(QR),
        .FULL(FULL), .ERR_FLT(ERR_FLT), .ERR_CON(ERR_CON), .ERR_OVF(ERR_OVF),
        .ERR_CLR(ERR_CLR), .DROPS(DROPS)
    );

    task automatic cycle(input logic clr, input logic ld, input logic [3:0] g,
                         input logic [7:0] bus, input logic qr, input logic eclr);
        int n;
        bit rej;
        CLR = clr; LD = ld; G = g; BUS = bus; QR = qr; ERR_CLR = eclr;
        @(posedge CLK);
        if (clr) begin
            m_fifo.delete();
            m_q = 8'h00; m_flt = 0; m_con = 0; m_ovf = 0; m_drops = 0;
        end else begin
            n = $countones(g);
            rej = 0;
            if (qr && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (eclr) begin
                m_flt = 0; m_con = 0; m_ovf = 0; m_drops = 0;
            end
            if (ld) begin
                if (n == 0) begin m_flt = 1; rej = 1; end
                else if (n >= 2) begin m_con = 1; rej = 1; end
                else if (m_fifo.size() < DEPTH) m_fifo.push_back(bus);
                else begin m_ovf = 1; rej = 1; end
            end
            if (rej && m_drops < 15) m_drops++;
            if (m_fifo.size() > 0) m_q = m_fifo[0];
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(1, 1, 4'b0001, 8'hA5, 0, 0);
        cycle(1, 1, 4'b0001, 8'hA5, 0, 0);
        total++;
        if ({QV, Q, FULL, ERR_FLT, ERR_CON, ERR_OVF, DROPS} !== 16'h0) begin
            bad++;
            $display("FAIL reset QV=%b Q=%h FULL=%b ERR=%b%b%b DROPS=%0d want all zero",
                     QV, Q, FULL, ERR_FLT, ERR_CON, ERR_OVF, DROPS);
        end
    endtask

    task automatic test_single_capture;
        cycle(0, 1, 4'b0100, 8'h3C, 0, 0);
        total++;
        if (QV !== 1'b1 || Q !== 8'h3C) begin
            bad++; $display("FAIL capture QV=%b Q=%h want QV=1 Q=3c", QV, Q);
        end
        cycle(0, 0, 4'b0000, 8'h00, 1, 0);
        total++;
        if (QV !== 1'b0 || Q !== 8'h3C) begin
            bad++; $display("FAIL pop_empty QV=%b Q=%h want QV=0 Q=3c", QV, Q);
        end
    endtask

    task automatic test_float_contention;
        cycle(0, 1, 4'b0000, 8'h11, 0, 0);
        cycle(0, 1, 4'b0110, 8'h22, 0, 0);
        total++;
        if (QV !== 1'b0 || ERR_FLT !== 1'b1 || ERR_CON !== 1'b1 || ERR_OVF !== 1'b0 || DROPS !== 4'd2) begin
            bad++;
            $display("FAIL flt_con QV=%b FLT=%b CON=%b OVF=%b DROPS=%0d want 0 1 1 0 2",
                     QV, ERR_FLT, ERR_CON, ERR_OVF, DROPS);
        end
        cycle(0, 0, 4'b0000, 8'h00, 0, 1);
        total++;
        if (ERR_FLT !== 1'b0 || ERR_CON !== 1'b0 || DROPS !== 4'd0) begin
            bad++; $display("FAIL err_clr FLT=%b CON=%b DROPS=%0d want 0 0 0", ERR_FLT, ERR_CON, DROPS);
        end
    endtask

    task automatic test_overflow;
        cycle(0, 1, 4'b0001, 8'd11, 0, 0);
        cycle(0, 1, 4'b0001, 8'd22, 0, 0);
        total++;
        if (FULL !== 1'b1 || Q !== 8'd11) begin
            bad++; $display("FAIL fill FULL=%b Q=%0d want FULL=1 Q=11", FULL, Q);
        end
        cycle(0, 1, 4'b0001, 8'd33, 0, 0);
        total++;
        if (ERR_OVF !== 1'b1 || DROPS !== 4'd1 || FULL !== 1'b1) begin
            bad++; $display("FAIL overflow OVF=%b DROPS=%0d FULL=%b want 1 1 1", ERR_OVF, DROPS, FULL);
        end
        cycle(0, 0, 4'b0000, 8'h00, 1, 0);
        total++;
        if (Q !== 8'd22 || QV !== 1'b1 || FULL !== 1'b0) begin
            bad++; $display("FAIL pop1 Q=%0d QV=%b FULL=%b want 22 1 0", Q, QV, FULL);
        end
        cycle(0, 0, 4'b0000, 8'h00, 1, 0);
        total++;
        if (QV !== 1'b0 || Q !== 8'd22) begin
            bad++; $display("FAIL pop2 QV=%b Q=%0d want QV=0 Q=22", QV, Q);
        end
    endtask

    task automatic test_full_push_pop;
        cycle(0, 1, 4'b0001, 8'd11, 0, 1);
        cycle(0, 1, 4'b0001, 8'd22, 0, 0);
        cycle(0, 1, 4'b1000, 8'h77, 1, 0);
        total++;
        if (ERR_OVF !== 1'b0 || FULL !== 1'b1 || Q !== 8'd22 || DROPS !== 4'd0) begin
            bad++;
            $display("FAIL full_push_pop OVF=%b FULL=%b Q=%0d DROPS=%0d want 0 1 22 0", ERR_OVF, FULL, Q, DROPS);
        end
        cycle(0, 0, 4'b0000, 8'h00, 1, 0);
        total++;
        if (Q !== 8'h77 || QV !== 1'b1) begin
            bad++; $display("FAIL pop_77 Q=%h QV=%b want 77 1", Q, QV);
        end
        cycle(0, 0, 4'b0000, 8'h00, 1, 0);
        total++;
        if (QV !== 1'b0) begin
            bad++; $display("FAIL drain QV=%b want 0", QV);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 20; i++) cycle(0, 1, 4'b0000, 8'h00, 0, 0);
        total++;
        if (DROPS !== 4'd15 || ERR_FLT !== 1'b1) begin
            bad++; $display("FAIL saturate DROPS=%0d FLT=%b want 15 1", DROPS, ERR_FLT);
        end
        cycle(0, 1, 4'b0000, 8'h00, 0, 1);
        total++;
        if (DROPS !== 4'd1 || ERR_FLT !== 1'b1) begin
            bad++; $display("FAIL clr_and_err DROPS=%0d FLT=%b want 1 1", DROPS, ERR_FLT);
        end
        cycle(0, 1, 4'b0010, 8'h5A, 0, 0);
        cycle(0, 1, 4'b0010, 8'h6B, 0, 0);
        cycle(1, 0, 4'b0000, 8'h00, 0, 0);
        total++;
        if (QV !== 1'b0 || FULL !== 1'b0 || Q !== 8'h00 || DROPS !== 4'd0 || ERR_FLT !== 1'b0) begin
            bad++;
            $display("FAIL clr_full QV=%b FULL=%b Q=%h DROPS=%0d FLT=%b want 0 0 00 0 0", QV, FULL, Q, DROPS, ERR_FLT);
        end
        cycle(0, 0, 4'b0000, 8'h00, 0, 0);
    endtask

    task automatic test_random;
        logic [3:0] g;
        logic [3:0] picks [8];
        picks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1111, 4'b0001};
        for (int i = 0; i < 400; i++) begin
            g = ($urandom_range(0, 3) == 0) ? 4'($urandom) : picks[$urandom_range(0, 7)];
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, g, 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            total++;
            if (Q !== m_q || QV !== (m_fifo.size() != 0) || FULL !== (m_fifo.size() == DEPTH) ||
                ERR_FLT !== m_flt || ERR_CON !== m_con || ERR_OVF !== m_ovf || DROPS !== 4'(m_drops)) begin
                bad++;
                $display("FAIL random[%0d] got Q=%h QV=%b FULL=%b ERR=%b%b%b DROPS=%0d want Q=%h QV=%b FULL=%b ERR=%b%b%b DROPS=%0d",
                         i, Q, QV, FULL, ERR_FLT, ERR_CON, ERR_OVF, DROPS, m_q, m_fifo.size() != 0,
                         m_fifo.size() == DEPTH, m_flt, m_con, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        CLR = 1; LD = 0; G = 0; BUS = 0; QR = 0; ERR_CLR = 0;
        test_reset;
        test_single_capture;
        test_float_contention;
        test_overflow;
        test_full_push_pop;
        test_saturation;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
